channel_mixer: RTL and testbench

//  Parametrised successor to the fixed 18-channel OPL3 mixer. After the operator engine signals "done",
//  it walks NUM_CHANNELS channels and reads each channel's operator outputs from an external 1-cycle-latency

---
 rtl/channel_mixer_pkg.sv | 25 ++
 rtl/channel_mixer_if.sv | 40 ++++
 rtl/channel_mixer_sat.sv | 25 ++
 rtl/channel_mixer.sv | 134 +++++++++++++
 tb/tb_channel_mixer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/channel_mixer_pkg.sv
// Shared types and default widths for the channel mixer: FSM state enum,
// operator/sample widths and an index-width helper.
package channel_mixer_pkg;

  localparam int OP_OUT_WIDTH     = 13;
  localparam int SAMPLE_WIDTH     = 16;
  localparam int DEF_NUM_CHANNELS = 18;
  localparam int DEF_NUM_OPS      = 2;
  localparam int DEF_NUM_OUTPUTS  = 4;
  localparam int DEF_ACC_WIDTH    = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LAST,
    ST_MIX,
    ST_OUT
  } mix_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/channel_mixer_if.sv
// Bus between the mixer and its environment: control strobes, operator
// memory read port, per-channel config lookup and the sample output.
interface channel_mixer_if
  import channel_mixer_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int NUM_OPS      = DEF_NUM_OPS,
  parameter int NUM_OUTPUTS  = DEF_NUM_OUTPUTS,
  parameter int OP_WIDTH     = OP_OUT_WIDTH,
  parameter int OUT_WIDTH    = SAMPLE_WIDTH
) ();
  localparam int AW   = idx_w(NUM_CHANNELS * NUM_OPS);
  localparam int CHW  = idx_w(NUM_CHANNELS);
  localparam int CFGW = NUM_OPS + NUM_OUTPUTS + 3;

  logic                                  start;
  logic                                  sample_clk_en;
  logic                                  busy;
  logic                                  overrun;
  logic                                  op_rd_en;
  logic [AW-1:0]                         op_rd_addr;
  logic signed [OP_WIDTH-1:0]            op_rd_data;
  logic [CHW-1:0]                        cfg_addr;
  logic [CFGW-1:0]                       cfg_data;
  logic                                  out_valid;
  logic [NUM_OUTPUTS-1:0][OUT_WIDTH-1:0] out_sample;
  logic [NUM_OUTPUTS-1:0]                out_sat;

  modport master (
    input  start, sample_clk_en, op_rd_data, cfg_data,
    output busy, overrun, op_rd_en, op_rd_addr, cfg_addr,
           out_valid, out_sample, out_sat
  );

  modport slave (
    output start, sample_clk_en, op_rd_data, cfg_data,
    input  busy, overrun, op_rd_en, op_rd_addr, cfg_addr,
           out_valid, out_sample, out_sat
  );
endinterface

// File: rtl/channel_mixer_sat.sv
// Combinational clip of one wrapped accumulator to the signed output range,
// flagging when clipping occurred.
module channel_mixer_sat #(
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  output logic [OUT_WIDTH-1:0] o_out,
  output logic                 o_sat
);
  // In range exactly when every bit from the output sign bit up matches.
  logic [ACC_WIDTH-OUT_WIDTH:0] w_hi;
  logic                         w_sat;

  assign w_hi  = i_acc[ACC_WIDTH-1:OUT_WIDTH-1];
  assign w_sat = ~((&w_hi) | ~(|w_hi));
  assign o_sat = w_sat;

  always_comb begin
    o_out = i_acc[OUT_WIDTH-1:0];
    if (w_sat)
      o_out = i_acc[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end
endmodule

// File: rtl/channel_mixer.sv
// Walks every channel after the operator engine finishes, sums carrier operators
// and pans them into wrapping accumulators, then emits clipped samples.
// CHANNEL_MIXER_ATTEN_EN enables a per-channel arithmetic right shift before mixing.
module channel_mixer
  import channel_mixer_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int NUM_OPS      = DEF_NUM_OPS,
  parameter int NUM_OUTPUTS  = DEF_NUM_OUTPUTS,
  parameter int OP_WIDTH     = OP_OUT_WIDTH,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH    = SAMPLE_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  channel_mixer_if.master bus
);
  localparam int AW  = idx_w(NUM_CHANNELS * NUM_OPS);
  localparam int CHW = idx_w(NUM_CHANNELS);
  localparam int OPW = idx_w(NUM_OPS);
  localparam int CSW = OP_WIDTH + $clog2(NUM_OPS) + 1;

  mix_state_e                            r_state, w_next;
  logic [CHW-1:0]                        r_ch;
  logic [OPW-1:0]                        r_op, r_pend_op;
  logic                                  r_pend;
  logic signed [CSW-1:0]                 r_ch_sum, w_mix_sum, w_rd_ext;
  logic [ACC_WIDTH-1:0]                  w_mix_ext;
  logic [NUM_OUTPUTS-1:0][ACC_WIDTH-1:0] r_acc;
  logic [NUM_OUTPUTS-1:0][OUT_WIDTH-1:0] w_clip, r_sample;
  logic [NUM_OUTPUTS-1:0]                w_clip_flag, r_sat;
  logic                                  r_valid, r_overrun;
  logic                                  w_busy, w_abort, w_last_op, w_last_ch;
  logic [NUM_OPS-1:0]                    w_mask;
  logic [NUM_OUTPUTS-1:0]                w_pan;

  assign w_mask    = bus.cfg_data[NUM_OPS-1:0];
  assign w_pan     = bus.cfg_data[NUM_OPS +: NUM_OUTPUTS];
  assign w_busy    = (r_state != ST_IDLE);
  assign w_abort   = w_busy & bus.sample_clk_en;
  assign w_last_op = (r_op == OPW'(NUM_OPS - 1));
  assign w_last_ch = (r_ch == CHW'(NUM_CHANNELS - 1));
  assign w_rd_ext  = {{(CSW-OP_WIDTH){bus.op_rd_data[OP_WIDTH-1]}}, bus.op_rd_data};

`ifdef CHANNEL_MIXER_ATTEN_EN
  assign w_mix_sum = r_ch_sum >>> bus.cfg_data[NUM_OPS+NUM_OUTPUTS +: 3];
`else
  assign w_mix_sum = r_ch_sum;
`endif
  assign w_mix_ext = {{(ACC_WIDTH-CSW){w_mix_sum[CSW-1]}}, w_mix_sum};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = ST_IDLE;
    else begin
      case (r_state)
        ST_IDLE: if (bus.start && !bus.sample_clk_en) w_next = ST_RD;
        ST_RD:   if (w_last_op) w_next = ST_LAST;
        ST_LAST: w_next = ST_MIX;
        ST_MIX:  w_next = w_last_ch ? ST_OUT : ST_RD;
        ST_OUT:  w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // r_pend marks that op_rd_data carries the operator read one cycle earlier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ch      <= '0;
      r_op      <= '0;
      r_pend    <= 1'b0;
      r_pend_op <= '0;
      r_ch_sum  <= '0;
      r_acc     <= '0;
      r_sample  <= '0;
      r_sat     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= w_busy & (bus.start | bus.sample_clk_en);
      r_pend    <= (r_state == ST_RD) & ~w_abort;
      r_pend_op <= r_op;
      if (w_abort) begin
        r_ch     <= '0;
        r_op     <= '0;
        r_ch_sum <= '0;
        r_acc    <= '0;
      end else begin
        if (r_pend && w_mask[r_pend_op]) r_ch_sum <= r_ch_sum + w_rd_ext;
        case (r_state)
          ST_RD: r_op <= w_last_op ? '0 : r_op + OPW'(1);
          ST_MIX: begin
            r_ch_sum <= '0;
            r_ch     <= w_last_ch ? '0 : r_ch + CHW'(1);
            for (int j = 0; j < NUM_OUTPUTS; j++)
              if (w_pan[j]) r_acc[j] <= r_acc[j] + w_mix_ext;
          end
          ST_OUT: begin
            r_sample <= w_clip;
            r_sat    <= w_clip_flag;
            r_acc    <= '0;
            r_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  channel_mixer_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat [NUM_OUTPUTS-1:0] (
    .i_acc (r_acc),
    .o_out (w_clip),
    .o_sat (w_clip_flag)
  );

  assign bus.busy       = w_busy;
  assign bus.overrun    = r_overrun;
  assign bus.op_rd_en   = (r_state == ST_RD);
  assign bus.op_rd_addr = AW'(r_ch) * AW'(NUM_OPS) + AW'(r_op);
  assign bus.cfg_addr   = r_ch;
  assign bus.out_valid  = r_valid;
  assign bus.out_sample = r_sample;
  assign bus.out_sat    = r_sat;
endmodule

// File: tb/tb_channel_mixer.sv
// Scoreboard bench for channel_mixer: directed scenarios plus random passes,
// expected samples computed from a behavioural model of the mixing rules.
module tb_channel_mixer;
  localparam int NCH  = 18;
  localparam int NOPS = 2;
  localparam int NOUT = 4;
  localparam int OPW  = 13;
  localparam int OW   = 16;
  localparam int ACCW = 20;
  localparam int LAT  = NCH * (NOPS + 2) + 2;
  localparam longint SMAX = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (OW - 1));

  typedef struct {
    logic [NOUT-1:0][OW-1:0] smp;
    logic [NOUT-1:0]         sat;
    int                      t0;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;
  exp_t q[$];
  exp_t me;
  logic [NOUT-1:0][OW-1:0] last_smp = '0;

  int              mem  [NCH*NOPS];
  logic [NOPS-1:0] mask [NCH];
  logic [NOUT-1:0] pan  [NCH];
  logic [2:0]      att  [NCH];

  channel_mixer_if #(.NUM_CHANNELS(NCH), .NUM_OPS(NOPS), .NUM_OUTPUTS(NOUT),
                     .OP_WIDTH(OPW), .OUT_WIDTH(OW)) bus ();

  channel_mixer #(.NUM_CHANNELS(NCH), .NUM_OPS(NOPS), .NUM_OUTPUTS(NOUT),
                  .OP_WIDTH(OPW), .ACC_WIDTH(ACCW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Operator memory with one cycle of read latency; config lookup is combinational.
  always @(posedge clk) if (bus.op_rd_en) bus.op_rd_data <= OPW'(mem[bus.op_rd_addr]);
  always_comb bus.cfg_data = {att[bus.cfg_addr], pan[bus.cfg_addr], mask[bus.cfg_addr]};

  task automatic chk(input string nm, input longint act, input longint req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    for (int j = 0; j < NOUT; j++) begin
      longint acc;
      longint w;
      acc = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        if (pan[ch][j]) begin
          longint s;
          s = 0;
          for (int op = 0; op < NOPS; op++)
            if (mask[ch][op]) s += mem[ch*NOPS+op];
`ifdef CHANNEL_MIXER_ATTEN_EN
          s = s >>> att[ch];
`endif
          acc += s;
        end
      end
      w = acc & ((64'sd1 <<< ACCW) - 1);
      if (w >= (64'sd1 <<< (ACCW - 1))) w -= (64'sd1 <<< ACCW);
      e.sat[j] = (w > SMAX) || (w < SMIN);
      if (w > SMAX) w = SMAX;
      else if (w < SMIN) w = SMIN;
      e.smp[j] = OW'(w);
    end
    e.t0 = 0;
    return e;
  endfunction

  task automatic fill(input int v, input logic [NOPS-1:0] m, input logic [NOUT-1:0] p,
                      input logic [2:0] a);
    for (int i = 0; i < NCH*NOPS; i++) mem[i] = v;
    for (int c = 0; c < NCH; c++) begin mask[c] = m; pan[c] = p; att[c] = a; end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NCH*NOPS; i++) mem[i] = int'($urandom_range(0, 8191)) - 4096;
    for (int c = 0; c < NCH; c++) begin
      mask[c] = NOPS'($urandom);
      pan[c]  = NOUT'($urandom);
      att[c]  = 3'($urandom);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // mode: 0 plain, 1 extra start at cycle 10, 2 abort at cycle 40, 3 reset at cycle 20
  task automatic run_pass(input int mode);
    exp_t e;
    int   t0;
    int   k;
    e = model();
    @(negedge clk);
    bus.start = 1'b1;
    t0 = cyc;
    e.t0 = t0;
    if (mode < 2) q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    if (mode == 1) begin
      wait_cyc(t0 + 10);
      chk("overrun_quiet", bus.overrun, 0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("overrun_on_start_busy", bus.overrun, 1);
    end else if (mode == 2) begin
      wait_cyc(t0 + 40);
      bus.sample_clk_en = 1'b1;
      @(negedge clk);
      bus.sample_clk_en = 1'b0;
      chk("abort_busy_low", bus.busy, 0);
      chk("abort_overrun", bus.overrun, 1);
      for (int j = 0; j < NOUT; j++)
        chk($sformatf("abort_hold[%0d]", j), $signed(bus.out_sample[j]), $signed(last_smp[j]));
    end else if (mode == 3) begin
      wait_cyc(t0 + 20);
      reset = 1'b1;
      #1;
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_rd_en", bus.op_rd_en, 0);
      chk("rst_mid_cfg_addr", bus.cfg_addr, 0);
      chk("rst_mid_sample", bus.out_sample, 0);
      last_smp = '0;
      @(negedge clk);
      reset = 1'b0;
    end
    k = 0;
    while (k < LAT + 10 && (q.size() != 0 || bus.busy)) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0 || bus.busy) begin
      vecs++;
      errs++;
      $display("FAIL pass_timeout: queue %0d, busy %0d after %0d cycles", q.size(), bus.busy, k);
      q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL spurious_out_valid: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        me = q.pop_front();
        chk("latency", cyc - me.t0, LAT);
        for (int j = 0; j < NOUT; j++)
          chk($sformatf("out_sample[%0d]", j), $signed(bus.out_sample[j]), $signed(me.smp[j]));
        chk("out_sat", bus.out_sat, me.sat);
        last_smp = me.smp;
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.sample_clk_en = 1'b0;
    fill(0, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_rd_en", bus.op_rd_en, 0);
    chk("rst_cfg_addr", bus.cfg_addr, 0);
    chk("rst_sample", bus.out_sample, 0);
    chk("rst_sat", bus.out_sat, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    fill(100, 2'b11, 4'b0001, 3'd0);
    run_pass(0);

    fill(0, 2'b00, 4'b0000, 3'd0);
    mask[0] = 2'b01; pan[0] = 4'b1111; mem[0] = -5; mem[1] = 7000;
    run_pass(0);

    fill(4095, 2'b11, 4'b1111, 3'd0);
    run_pass(0);
    fill(-4095, 2'b11, 4'b1111, 3'd0);
    run_pass(0);

    fill_rand();
    run_pass(1);

    fill_rand();
    run_pass(2);
    run_pass(0);

    // Idle sample strobe together with start: start is dropped, no overrun.
    @(negedge clk);
    bus.start = 1'b1;
    bus.sample_clk_en = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sample_clk_en = 1'b0;
    chk("abort_wins_busy", bus.busy, 0);
    chk("abort_wins_overrun", bus.overrun, 0);
    repeat (2) @(negedge clk);

    fill(0, 2'b00, 4'b0000, 3'd0);
    mask[0] = 2'b11; pan[0] = 4'b0001; att[0] = 3'd2; mem[0] = -4; mem[1] = -5;
    run_pass(0);

    fill_rand();
    run_pass(3);

    for (int n = 0; n < 15; n++) begin
      fill_rand();
      run_pass(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
